// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the multiply sequencer that
// borrows it: ALU opcode encodings, the datapath width, and the sequencer
// state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_W = 16;

   // ALU opcode encodings
   localparam logic [2:0] ALU_ROL = 3'd0;
   localparam logic [2:0] ALU_SLL = 3'd1;
   localparam logic [2:0] ALU_ROR = 3'd2;
   localparam logic [2:0] ALU_SRA = 3'd3;
   localparam logic [2:0] ALU_ADD = 3'd4;
   localparam logic [2:0] ALU_OR  = 3'd5;
   localparam logic [2:0] ALU_XOR = 3'd6;
   localparam logic [2:0] ALU_AND = 3'd7;

   // Multiply sequencer states. The correction states are only reachable
   // when signed multiplication is compiled in.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ITER   = 3'd1,
      ST_CORR_A = 3'd2,
      ST_CORR_B = 3'd3,
      ST_DONE   = 3'd4
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle multiplier that borrows the shared combinational ALU to build a
// 2*WIDTH-bit product by shift-and-add, one ALU ADD per cycle. The parent
// muxes the ALU inputs to this block while alu_own is high.
//
// Latency from accept cycle T: resp_valid rises at T+17 (unsigned) or T+19
// (signed, two trailing correction subtractions of the high half).
//
// Build option:
//   ALU_MUL_SIGNED_EN  when defined, req_sign selects a two's-complement
//                      multiply; otherwise every request is unsigned and
//                      alu_invB is tied low.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_a, req_b, req_sign   multiplicand, multiplier, signed select
//   resp_valid/resp_ready    response handshake
//   resp_prod                product, held stable while resp_valid
//   alu_own                  this block drives the ALU this cycle
//   alu_a, alu_b, alu_cin    ALU operands / carry-in
//   alu_op                   ALU opcode (ADD while owned)
//   alu_invA/invB/sign       ALU operand-invert and signed-mode controls
//   alu_out, alu_ofl         ALU result and carry-out (unsigned mode)
//
// All ALU-facing and handshake outputs are registered; next-cycle ALU
// operands are formed from the next-state datapath values.
// -----------------------------------------------------------------------------
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WIDTH-1:0]     req_a,
   input  logic [WIDTH-1:0]     req_b,
   input  logic                 req_sign,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [2*WIDTH-1:0]   resp_prod,
   output logic                 alu_own,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic                 alu_cin,
   output logic [2:0]           alu_op,
   output logic                 alu_invA,
   output logic                 alu_invB,
   output logic                 alu_sign,
   input  logic [WIDTH-1:0]     alu_out,
   input  logic                 alu_ofl
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mul_state_t            state_q, state_d;
   logic [WIDTH-1:0]      a_q, a_d;
   logic [WIDTH-1:0]      b_q, b_d;
   logic [WIDTH-1:0]      phi_q, phi_d;
   logic [WIDTH-1:0]      plo_q, plo_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  req_ready_q;
   logic                  resp_valid_q;
   logic [2*WIDTH-1:0]    resp_prod_q;
   logic                  alu_own_q, alu_own_d;
   logic [WIDTH-1:0]      alu_a_q, alu_a_d;
   logic [WIDTH-1:0]      alu_b_q, alu_b_d;
   logic                  alu_cin_q, alu_cin_d;
   logic [2:0]            alu_op_q, alu_op_d;
   logic                  alu_invb_q, alu_invb_d;

`ifdef ALU_MUL_SIGNED_EN
   logic                  s_q, s_d;
`else
   // Signed select is ignored in the unsigned-only build.
   logic                  unused_req_sign;
   assign unused_req_sign = req_sign;
`endif

   // ---------------------------------------------------------------------------
   // Next-state datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      cnt_d   = cnt_q;
`ifdef ALU_MUL_SIGNED_EN
      s_d     = s_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
`ifdef ALU_MUL_SIGNED_EN
               s_d     = req_sign;
`endif
               phi_d   = '0;
               plo_d   = req_b;
               cnt_d   = '0;
               state_d = ST_ITER;
            end
         end
         ST_ITER: begin
            // {carry, sum, P_lo} shifted right by one: the carry becomes the
            // new P_hi MSB and the sum LSB moves into P_lo.
            {phi_d, plo_d} = {alu_ofl, alu_out, plo_q[WIDTH-1:1]};
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
`ifdef ALU_MUL_SIGNED_EN
               state_d = s_q ? ST_CORR_A : ST_DONE;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef ALU_MUL_SIGNED_EN
         // Signed fix-up: subtract (A negative ? B : 0) and (B negative ? A : 0)
         // from the high half. Both states always run so latency is fixed.
         ST_CORR_A: begin
            phi_d   = alu_out;
            state_d = ST_CORR_B;
         end
         ST_CORR_B: begin
            phi_d   = alu_out;
            state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-cycle ALU drive, derived from the state being entered
   // ---------------------------------------------------------------------------
   always_comb begin
      alu_own_d  = 1'b0;
      alu_a_d    = '0;
      alu_b_d    = '0;
      alu_cin_d  = 1'b0;
      alu_op_d   = 3'd0;
      alu_invb_d = 1'b0;
      case (state_d)
         ST_ITER: begin
            alu_own_d = 1'b1;
            alu_op_d  = ALU_ADD;
            alu_a_d   = phi_d;
            alu_b_d   = plo_d[0] ? a_d : '0;
         end
`ifdef ALU_MUL_SIGNED_EN
         // Subtraction as P_hi + ~x + 1.
         ST_CORR_A: begin
            alu_own_d  = 1'b1;
            alu_op_d   = ALU_ADD;
            alu_a_d    = phi_d;
            alu_b_d    = a_d[WIDTH-1] ? b_d : '0;
            alu_invb_d = 1'b1;
            alu_cin_d  = 1'b1;
         end
         ST_CORR_B: begin
            alu_own_d  = 1'b1;
            alu_op_d   = ALU_ADD;
            alu_a_d    = phi_d;
            alu_b_d    = b_d[WIDTH-1] ? a_d : '0;
            alu_invb_d = 1'b1;
            alu_cin_d  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      cnt_q <= cnt_d;
`ifdef ALU_MUL_SIGNED_EN
      s_q   <= s_d;
`endif
      if (rst) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_prod_q  <= '0;
         alu_own_q    <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cin_q    <= 1'b0;
         alu_op_q     <= 3'd0;
         alu_invb_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= (state_d == ST_IDLE);
         resp_valid_q <= (state_d == ST_DONE);
         if (state_d == ST_DONE) resp_prod_q <= {phi_d, plo_d};
         alu_own_q    <= alu_own_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cin_q    <= alu_cin_d;
         alu_op_q     <= alu_op_d;
         alu_invb_q   <= alu_invb_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_prod  = resp_prod_q;
   assign alu_own    = alu_own_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign alu_op     = alu_op_q;
   assign alu_invB   = alu_invb_q;
   // Operand A is never inverted and the ALU always runs unsigned so that
   // alu_ofl is the carry-out.
   assign alu_invA   = 1'b0;
   assign alu_sign   = 1'b0;

endmodule
